// File: rtl/key_debounce.sv
// Multi-channel pushbutton debouncer with press/release edge pulses and auto-repeat.
// Each channel is an independent four-state FSM fed by a two-flop synchronizer.
module key_debounce #(
   parameter int unsigned NUM_KEYS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
   localparam bit               RPT_EN     = (REPEAT_DELAY != 0);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [NUM_KEYS-1:0] sync1, sync2;
   logic [NUM_KEYS-1:0] state_c, press_c, release_c, repeat_c;

   // Synchronizer idles at the released (high) level
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= KEY;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      state_t           state, state_nx;
      logic [DB_W-1:0]  db_cnt, db_cnt_nx;
      logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nx;
      logic             rpt_phase, rpt_phase_nx;
      logic             down;
      logic             ch_press, ch_release, ch_repeat;

      assign down = ~sync2[i];

      always_ff @(posedge CLOCK_50) begin
         if (!RESET_N) begin
            state     <= RELEASED;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
         end else begin
            state     <= state_nx;
            db_cnt    <= db_cnt_nx;
            rpt_cnt   <= rpt_cnt_nx;
            rpt_phase <= rpt_phase_nx;
         end
      end

      // rpt_phase selects the initial delay (0) or the steady repeat rate (1)
      always_comb begin
         state_nx     = state;
         db_cnt_nx    = db_cnt;
         rpt_cnt_nx   = rpt_cnt;
         rpt_phase_nx = rpt_phase;
         ch_press     = 1'b0;
         ch_release   = 1'b0;
         ch_repeat    = 1'b0;
         case (state)
            RELEASED: begin
               if (down) begin
                  state_nx  = PRESS_WAIT;
                  db_cnt_nx = '0;
               end
            end
            PRESS_WAIT: begin
               if (!down) begin
                  state_nx  = RELEASED;
                  db_cnt_nx = '0;
               end else if (db_cnt == DB_LAST) begin
                  state_nx     = PRESSED;
                  ch_press     = 1'b1;
                  rpt_cnt_nx   = '0;
                  rpt_phase_nx = 1'b0;
               end else begin
                  db_cnt_nx = db_cnt + DB_W'(1);
               end
            end
            PRESSED: begin
               if (!down) begin
                  state_nx  = RELEASE_WAIT;
                  db_cnt_nx = '0;
               end else if (RPT_EN) begin
                  if (rpt_cnt == (rpt_phase ? RATE_LAST : DELAY_LAST)) begin
                     ch_repeat    = 1'b1;
                     rpt_cnt_nx   = '0;
                     rpt_phase_nx = 1'b1;
                  end else begin
                     rpt_cnt_nx = rpt_cnt + RPT_W'(1);
                  end
               end
            end
            RELEASE_WAIT: begin
               if (down) begin
                  state_nx  = PRESSED;
                  db_cnt_nx = '0;
               end else if (db_cnt == DB_LAST) begin
                  state_nx   = RELEASED;
                  ch_release = 1'b1;
               end else begin
                  db_cnt_nx = db_cnt + DB_W'(1);
               end
            end
            default: state_nx = RELEASED;
         endcase
      end

      assign state_c[i]   = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
      assign press_c[i]   = ch_press;
      assign release_c[i] = ch_release;
      assign repeat_c[i]  = ch_repeat;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         key_state   <= '0;
         key_press   <= '0;
         key_release <= '0;
         key_repeat  <= '0;
      end else begin
         key_state   <= state_c;
         key_press   <= press_c;
         key_release <= release_c;
         key_repeat  <= repeat_c;
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: per-edge expected outputs are queued with the
// stimulus and compared as each clock edge completes.
module tb_key_debounce;
   localparam int unsigned N = 4;

   typedef struct packed {
      logic [N-1:0] st;
      logic [N-1:0] pr;
      logic [N-1:0] rl;
      logic [N-1:0] rp;
   } obs_t;

   typedef struct packed {
      logic         rst_n;
      logic [N-1:0] key;
   } stim_t;

   logic         CLOCK_50;
   logic         RESET_N;
   logic [N-1:0] KEY;
   logic [N-1:0] st, pr, rl, rp;
   logic [N-1:0] st_nr, pr_nr, rl_nr, rp_nr;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   key_debounce #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
      .key_state(st), .key_press(pr), .key_release(rl), .key_repeat(rp)
   );

   key_debounce #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(0), .REPEAT_RATE(5)) dut_nr (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
      .key_state(st_nr), .key_press(pr_nr), .key_release(rl_nr), .key_repeat(rp_nr)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push(input logic r, input logic [N-1:0] k, input obs_t e);
      stim_t s;
      s.rst_n = r;
      s.key   = k;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      KEY     = '1;
      repeat (3) @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      obs_t e, o;
      stim_t s;
      for (int k = 0; k < 8; k++) push(k >= 4, (k < 4) ? 4'b0000 : 4'b1111, '0);
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st, pr, rl, rp};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset edge %0d: got %h expected %h", k, o, e);
         end
         o = {st_nr, pr_nr, rl_nr, rp_nr};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset_nr edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   task automatic test_clean_press();
      obs_t e, o;
      stim_t s;
      do_reset();
      for (int k = 0; k < 72; k++) begin
         e = '0;
         e.st[0] = (k >= 10 && k < 62);
         e.pr[0] = (k == 10);
         e.rp[0] = (k >= 30 && k <= 50 && (k - 30) % 5 == 0);
         e.rl[0] = (k == 62);
         push(1'b1, (k < 52) ? 4'b1110 : 4'b1111, e);
      end
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st, pr, rl, rp};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL clean_press edge %0d: got st=%b pr=%b rl=%b rp=%b expected st=%b pr=%b rl=%b rp=%b",
                     k, o.st, o.pr, o.rl, o.rp, e.st, e.pr, e.rl, e.rp);
         end
      end
   endtask

   task automatic test_bounce_reject();
      obs_t e, o;
      stim_t s;
      logic [N-1:0] k1;
      do_reset();
      for (int k = 0; k < 32; k++) begin
         k1 = ((k < 5) || (k >= 8 && k < 12)) ? 4'b1101 : 4'b1111;
         push(1'b1, k1, '0);
      end
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st, pr, rl, rp};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL bounce_reject edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   task automatic test_release_bounce();
      obs_t e, o;
      stim_t s;
      logic [N-1:0] k2;
      do_reset();
      // pressed 0..19, glitch high 20..23, low 24..25, high held from R=26
      for (int k = 0; k < 46; k++) begin
         k2 = ((k < 20) || (k >= 24 && k < 26)) ? 4'b1011 : 4'b1111;
         e = '0;
         e.st[2] = (k >= 10 && k < 36);
         e.pr[2] = (k == 10);
         e.rl[2] = (k == 36);
         push(1'b1, k2, e);
      end
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st, pr, rl, rp};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL release_bounce edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      obs_t e, o;
      stim_t s;
      do_reset();
      // reset low at edges 15..17; edge 18 is the new edge 0
      for (int k = 0; k < 42; k++) begin
         e = '0;
         e.st[3] = (k >= 10 && k < 15) || (k >= 28);
         e.pr[3] = (k == 10) || (k == 28);
         push(!(k >= 15 && k <= 17), 4'b0111, e);
      end
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st, pr, rl, rp};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset_mid_hold edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   task automatic test_simultaneous();
      obs_t e, o;
      stim_t s;
      do_reset();
      for (int k = 0; k < 30; k++) begin
         e = '0;
         e.st = (k >= 10 && k < 25) ? 4'b1001 : 4'b0000;
         e.pr = (k == 10) ? 4'b1001 : 4'b0000;
         e.rl = (k == 25) ? 4'b1001 : 4'b0000;
         push(1'b1, (k < 15) ? 4'b0110 : 4'b1111, e);
      end
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st, pr, rl, rp};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL simultaneous edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   task automatic test_repeat_disabled();
      obs_t e, o;
      stim_t s;
      do_reset();
      for (int k = 0; k < 200; k++) begin
         e = '0;
         e.st[0] = (k >= 10);
         e.pr[0] = (k == 10);
         push(1'b1, 4'b1110, e);
      end
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front();
         RESET_N = s.rst_n;
         KEY     = s.key;
         @(negedge CLOCK_50);
         e = exp_q.pop_front();
         o = {st_nr, pr_nr, rl_nr, rp_nr};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL repeat_disabled edge %0d: got %h expected %h", k, o, e);
         end
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      KEY     = '1;
      @(negedge CLOCK_50);
      test_reset();
      test_clean_press();
      test_bounce_reject();
      test_release_bounce();
      test_reset_mid_hold();
      test_simultaneous();
      test_repeat_disabled();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
